reset_sequencer: RTL

Generates the design's staged reset outputs from a single board reset and a PLL lock indication. It is the issuing end of the reset path: each `reset_n_o` bit drives a per-domain reset synchronizer downstream. It holds all outputs low for a minimum time, then waits for a stable lock. It then releases the outputs one at a time in index order, and re-runs the sequence on lock loss or on a soft-reset request.

---
 rtl/reset_sequencer_pkg.sv | 16 +
 rtl/sync_2ff.sv | 27 ++
 rtl/reset_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: shared state encodings and default timing for the reset sequencer
package reset_sequencer_pkg;

   typedef enum logic [1:0] {
      RST_ASSERT    = 2'd0,
      RST_WAIT_LOCK = 2'd1,
      RST_RELEASE   = 2'd2,
      RST_RUN       = 2'd3
   } rst_state_t;

   localparam int DEF_NUM_OUTPUTS  = 3;
   localparam int DEF_HOLD_CYCLES  = 16;
   localparam int DEF_STAGE_CYCLES = 8;
   localparam int DEF_LOCK_FILTER  = 4;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop level synchronizer with asynchronous active-low clear
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_clr_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // first flop may go metastable; second flop gives it a cycle to settle
   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset release gated by a filtered PLL lock, with soft-reset handshake
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int NUM_OUTPUTS  = DEF_NUM_OUTPUTS,
   parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
   parameter int STAGE_CYCLES = DEF_STAGE_CYCLES,
   parameter int LOCK_FILTER  = DEF_LOCK_FILTER
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   lock_i,
   input  logic                   req_i,
   output logic                   ack_o,
   output logic [NUM_OUTPUTS-1:0] reset_n_o,
   output logic                   ready_o
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int SW = $clog2(STAGE_CYCLES + 1);
   localparam int FW = $clog2(LOCK_FILTER + 1);
   localparam int KW = $clog2(NUM_OUTPUTS + 1);

   rst_state_t             r_state;
   rst_state_t             w_state_nxt;
   logic [HW-1:0]          r_hold;
   logic [HW-1:0]          w_hold_nxt;
   logic [SW-1:0]          r_stage;
   logic [SW-1:0]          w_stage_nxt;
   logic [KW-1:0]          r_k;
   logic [KW-1:0]          w_k_nxt;
   logic [NUM_OUTPUTS-1:0] r_rst_n;
   logic [NUM_OUTPUTS-1:0] w_rst_n_nxt;
   logic                   r_ready;
   logic                   w_ready_nxt;
   logic                   r_ack;
   logic                   w_ack_nxt;
   logic [FW-1:0]          r_lock_cnt;
   logic                   w_lock_s;
   logic                   w_lock_ok;
   logic                   w_take_req;
   logic                   w_abort;

   sync_2ff #(.WIDTH(1)) u_lock_sync (
      .i_clk   (clk_i),
      .i_clr_n (reset_n_i),
      .i_d     (lock_i),
      .o_q     (w_lock_s)
   );

   // count consecutive synchronized-high lock cycles, saturating; any low sample restarts it
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)
         r_lock_cnt <= '0;
      else if (!w_lock_s)
         r_lock_cnt <= '0;
      else if (r_lock_cnt != FW'(LOCK_FILTER))
         r_lock_cnt <= r_lock_cnt + 1'b1;
   end

   assign w_lock_ok  = (r_lock_cnt == FW'(LOCK_FILTER));
   assign w_take_req = (r_state == RST_RUN) && req_i && !r_ack;
   assign w_abort    = w_take_req || (!w_lock_ok && (r_state == RST_RELEASE || r_state == RST_RUN));

   // state register and registered outputs; hold starts one above the entry load so the
   // first edge after reset behaves like the edge that enters ASSERT
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= RST_ASSERT;
         r_hold  <= HW'(HOLD_CYCLES);
         r_stage <= '0;
         r_k     <= '0;
         r_rst_n <= '0;
         r_ready <= 1'b0;
         r_ack   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_hold  <= w_hold_nxt;
         r_stage <= w_stage_nxt;
         r_k     <= w_k_nxt;
         r_rst_n <= w_rst_n_nxt;
         r_ready <= w_ready_nxt;
         r_ack   <= w_ack_nxt;
      end
   end

   // next-state: timed hold, lock wait, staged release; lock loss or accepted request restarts
   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_stage_nxt = r_stage;
      w_k_nxt     = r_k;
      w_rst_n_nxt = r_rst_n;
      w_ready_nxt = r_ready;
      w_ack_nxt   = (r_ack && req_i) || w_take_req;
      case (r_state)
         RST_ASSERT: begin
            w_rst_n_nxt = '0;
            w_ready_nxt = 1'b0;
            if (r_hold != '0) begin
               w_hold_nxt = r_hold - 1'b1;
            end else if (w_lock_ok) begin
               w_state_nxt    = RST_RELEASE;
               w_rst_n_nxt[0] = 1'b1;
               w_k_nxt        = KW'(1);
               w_stage_nxt    = SW'(STAGE_CYCLES - 1);
            end else begin
               w_state_nxt = RST_WAIT_LOCK;
            end
         end
         RST_WAIT_LOCK: begin
            if (w_lock_ok) begin
               w_state_nxt    = RST_RELEASE;
               w_rst_n_nxt[0] = 1'b1;
               w_k_nxt        = KW'(1);
               w_stage_nxt    = SW'(STAGE_CYCLES - 1);
            end
         end
         RST_RELEASE: begin
            if (r_stage != '0) begin
               w_stage_nxt = r_stage - 1'b1;
            end else if (r_k < KW'(NUM_OUTPUTS)) begin
               w_rst_n_nxt[r_k] = 1'b1;
               w_k_nxt          = r_k + 1'b1;
               w_stage_nxt      = SW'(STAGE_CYCLES - 1);
            end else begin
               w_state_nxt = RST_RUN;
               w_ready_nxt = 1'b1;
            end
         end
         default: ;
      endcase
      if (w_abort) begin
         w_state_nxt = RST_ASSERT;
         w_rst_n_nxt = '0;
         w_ready_nxt = 1'b0;
         w_hold_nxt  = HW'(HOLD_CYCLES - 1);
      end
   end

   assign reset_n_o = r_rst_n;
   assign ready_o   = r_ready;
   assign ack_o     = r_ack;

endmodule
